// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, register-zero constant and ID/EX control bubble
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 16;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] dst;
        logic [CTRL_W-1:0] ctrl;
    } idex_ctrl_t;
    localparam idex_ctrl_t IDEX_BUBBLE = '0;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: per-operand writer match, MEM/WB/RF select and load-use/EX stall detect
//   src, uses, rf_data           : source register, use bit, register file read data
//   ex_*, mem_*, wb_*            : in-flight writer state of EX, MEM and WB stages
//   fwd_data                     : resolved operand
//   needs_stall                  : operand depends on a result not yet available
module operand_bypass
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              needs_stall
);
    logic live, ex_hit, mem_hit, wb_hit;
    always_comb begin
        live        = uses && src != REG_ZERO;
        ex_hit      = live && ex_valid && ex_reg_write && ex_dst == src;
        mem_hit     = live && mem_reg_write && mem_dst == src;
        wb_hit      = live && wb_reg_write && wb_dst == src;
        // a load in MEM has no data yet, so it falls through to WB/RF and stalls instead
        fwd_data    = (mem_hit && !mem_mem_read) ? mem_data : wb_hit ? wb_data : rf_data;
        needs_stall = ex_hit || (mem_hit && mem_mem_read);
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: operand bypass, RAW hazard stall, flush and ID/EX pipeline register
//   id_*        : decoded instruction and register file read data
//   mem_*, wb_* : downstream writers used for forwarding and load-use detection
//   flush       : taken branch in EX, bubble into EX
//   stall_if_id : combinational hold request for PC and IF/ID
//   ex_*        : registered ID/EX outputs; stall_count: saturating stall-cycle counter
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [REG_AW-1:0] ex_dst,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              rs_stall, rt_stall, hazard;
    operand_bypass u_rs (
        .src(id_rs), .uses(id_uses_rs), .rf_data(id_rs_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .fwd_data(rs_fwd), .needs_stall(rs_stall)
    );
    operand_bypass u_rt (
        .src(id_rt), .uses(id_uses_rt), .rf_data(id_rt_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .fwd_data(rt_fwd), .needs_stall(rt_stall)
    );
    always_comb begin
        hazard      = id_valid && (rs_stall || rt_stall);
        stall_if_id = hazard && !flush;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ex_valid, ex_reg_write, ex_mem_read, ex_dst, ex_ctrl} <= IDEX_BUBBLE;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            stall_count <= '0;
        end else begin
            if (flush || hazard) begin
                {ex_valid, ex_reg_write, ex_mem_read, ex_dst, ex_ctrl} <= IDEX_BUBBLE;
                ex_rs_data <= '0;
                ex_rt_data <= '0;
                ex_imm     <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_reg_write <= id_valid && id_reg_write;
                ex_mem_read  <= id_valid && id_mem_read;
                ex_dst       <= id_dst;
                ex_ctrl      <= id_ctrl;
                ex_rs_data   <= rs_fwd;
                ex_rt_data   <= rt_fwd;
                ex_imm       <= id_imm;
            end
            if (stall_if_id && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipeline; directly downstream of the register file read ports.
- Captures the two register-file read operands for the instruction in ID.
- Resolves them against in-flight writers: MEM-stage result, WB-stage write (same-cycle write/read bypass), else raw register-file data.
- Detects RAW hazards that cannot be bypassed, stalls IF/ID, inserts bubbles, honours branch flush, and latches the ID/EX pipeline register.

Parameters:
- DATA_W, 32, operand/immediate width.
- REG_AW, 5, register address width.
- CTRL_W, 16, opaque EX/MEM/WB control bundle width, passed through untouched.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register numbers.
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs/rt.
- id_rs_data, id_rt_data  in  DATA_W  register file read data.
- id_dst  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes id_dst.
- id_mem_read  in  1  instruction is a load.
- id_imm  in  DATA_W  extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- flush  in  1  taken branch/jump resolved in EX; kill ID.
- mem_reg_write, mem_mem_read  in  1  MEM-stage instruction writes reg / is a load.
- mem_dst  in  REG_AW; mem_data  in  DATA_W  MEM-stage ALU result.
- wb_reg_write  in  1; wb_dst  in  REG_AW; wb_data  in  DATA_W  same signals that drive the register file write port.
- stall_if_id  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered.
- ex_dst  out  REG_AW; ex_rs_data, ex_rt_data, ex_imm  out  DATA_W; ex_ctrl  out  CTRL_W  registered.
- stall_count  out  CNT_W  registered stall-cycle counter.

Behaviour:
- Reset (async, active-high): every registered output = 0, stall_count = 0.
- Matching a source against a writer requires all of:
  - writer's reg_write = 1;
  - writer's dst == source register;
  - source register != 0;
  - the use bit for that source (id_uses_rs / id_uses_rt) = 1.
  - Register 0 never matches and never forwards.
- Operand select, per operand, priority order:
  - MEM match with mem_mem_read = 0 → mem_data;
  - else WB match → wb_data;
  - else id_*_data.
- Hazard (stall) when id_valid = 1 and any used source matches:
  - the EX stage (ex_valid, ex_reg_write, ex_dst from this block's own registers), or
  - the MEM stage with mem_mem_read = 1.
  - Otherwise no stall.
- stall_if_id = hazard & ~flush. A flush kills ID, so no stall is raised.
- Clock edge, in priority order:
  - flush: bubble into EX.
  - else hazard: bubble into EX; the ID instruction is re-presented next cycle.
  - else: latch the selected operands plus id_* fields; ex_valid = id_valid.
- Bubble means ex_valid = ex_reg_write = ex_mem_read = 0, ex_ctrl = 0, ex_dst = 0; data fields are don't-care but are driven to 0.
- When id_valid = 0, control fields are still latched but ex_reg_write and ex_mem_read are forced to 0.
- Latency: 1 cycle ID→EX.
- Stall lengths:
  - ALU producer directly ahead: 1 stall cycle, then MEM forward.
  - Load directly ahead: 2 stall cycles, then WB forward.
  - A hazard on both rs and rt is still one stall per cycle, not additive.
- stall_count increments each cycle stall_if_id = 1 and saturates at all-ones (no wrap).
- Reset asserted mid-stall: outputs clear immediately; no stall after release until a new hazard appears.

Decomposition:
- Shared package pipe_pkg: REG_AW, DATA_W, CTRL_W, REG_ZERO = 5'd0, and the bubble constant for the ID/EX control fields.
- Sub-module operand_bypass: combinational per-operand match plus 3-way select, emitting fwd_data and needs_stall. Instantiated twice (rs, rt).

Test Plan:
- Reset with all inputs nonzero → all ex_* = 0, stall_count = 0, stall_if_id = 0.
- WB writes r8 = 0x1234 while ID reads rs = r8 with id_rs_data = 0 → ex_rs_data = 0x1234 next cycle, no stall.
- add r9 into EX, then ID uses rt = r9:
  - 1 stall cycle with a bubble into EX;
  - then mem_data = 0x55 is forwarded → ex_rt_data = 0x55;
  - stall_count = 1.
- lw r10 then a dependent instruction using r10 → stall_if_id high for exactly 2 cycles, then ex_rs_data = wb_data = 0xCAFE.
- ID uses r0 while MEM and WB both target r0 with data 0xFFFF → ex operand = id_*_data, no stall.
- Hazard and flush in the same cycle → stall_if_id = 0, bubble into EX, stall_count unchanged.
